// File: rtl/and_gather.sv
// and_gather: packs up to N words into a frame, padding unwritten slots with all-ones for a downstream AND tree
module and_gather #(
  parameter int N = 2,
  parameter int WIDTH = 1,
  parameter int CW = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data [0:N-1],
  output logic [CW-1:0]    out_count
);
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic {FILL, FULL} state_t;
  state_t state;
  logic [IW-1:0] idx;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FILL;
      idx       <= '0;
      out_data  <= '{default: {WIDTH{1'b1}}};
      out_count <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else if (state == FILL) begin
      if (in_valid) begin
        out_data[idx] <= in_data;
        if (idx == IW'(N - 1) || in_last) begin
          state     <= FULL;
          out_count <= CW'(idx) + CW'(1);
          idx       <= '0;
          in_ready  <= 1'b0;
          out_valid <= 1'b1;
        end else begin
          idx <= idx + IW'(1);
        end
      end
    end else if (out_ready) begin
      state     <= FILL;
      out_data  <= '{default: {WIDTH{1'b1}}};
      out_count <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_and_gather.sv
// tb_and_gather: directed checks of and_gather at N=4/WIDTH=8 plus an N=1 build
module tb_and_gather;
  logic clk, rst_n;
  logic in_valid, in_ready, in_last, out_valid, out_ready;
  logic [7:0] in_data;
  logic [7:0] out_data [0:3];
  logic [2:0] out_count;
  logic v1, r1, l1, ov1, or1;
  logic [7:0] d1;
  logic [7:0] od1 [0:0];
  logic oc1;
  int n_cmp = 0, n_err = 0;

  and_gather #(.N(4), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count)
  );

  and_gather #(.N(1), .WIDTH(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .in_data(d1),
    .in_last(l1), .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_count(oc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h5C; in_last = 1'b1; out_ready = 1'b0;
    v1 = 1'b0; d1 = 8'h00; l1 = 1'b0; or1 = 1'b0;
    step; step;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", out_count); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out_data[i] !== 8'hFF) begin n_err++; $display("FAIL reset_slot[%0d]: got %h want ff", i, out_data[i]); end
    end
    rst_n = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    step;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_idle_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_full_frame;
    logic [7:0] exp [0:3];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_in_ready[%0d]: got %b want 1", i, in_ready); end
      in_valid = 1'b1; in_data = exp[i]; in_last = 1'b0;
      step;
    end
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL full_out_valid: got %b want 1", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_count !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d want 4", out_count); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out_data[i] !== exp[i]) begin n_err++; $display("FAIL full_slot[%0d]: got %h want %h", i, out_data[i], exp[i]); end
    end
    out_ready = 1'b1; step; out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_release_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_count !== 3'd0) begin n_err++; $display("FAIL full_release_count: got %0d want 0", out_count); end
  endtask

  task automatic test_short_frame;
    logic [7:0] exp [0:3];
    exp = '{8'hF0, 8'h0F, 8'hFF, 8'hFF};
    in_valid = 1'b1; in_data = 8'hF0; in_last = 1'b0; step;
    in_data = 8'h0F; in_last = 1'b1; step;
    in_valid = 1'b0; in_last = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL short_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_count !== 3'd2) begin n_err++; $display("FAIL short_count: got %0d want 2", out_count); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out_data[i] !== exp[i]) begin n_err++; $display("FAIL short_slot[%0d]: got %h want %h", i, out_data[i], exp[i]); end
    end
    out_ready = 1'b1; step; out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [7:0] exp [0:3];
    exp = '{8'h5A, 8'hA5, 8'h3C, 8'hFF};
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = exp[i]; in_last = (i == 2); step;
    end
    in_data = 8'h00; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step;
      n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hs[%0d]: got valid=%b ready=%b want 1/0", c, out_valid, in_ready); end
      n_cmp++; if (out_count !== 3'd3) begin n_err++; $display("FAIL bp_count[%0d]: got %0d want 3", c, out_count); end
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (out_data[i] !== exp[i]) begin n_err++; $display("FAIL bp_slot[%0d][%0d]: got %h want %h", c, i, out_data[i], exp[i]); end
      end
    end
    out_ready = 1'b1; step; out_ready = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release: got ready=%b valid=%b want 1/0", in_ready, out_valid); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out_data[i] !== 8'hFF) begin n_err++; $display("FAIL bp_nobypass[%0d]: got %h want ff", i, out_data[i]); end
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_gapped;
    logic [7:0] exp [0:3];
    logic [7:0] dat [0:6];
    logic [6:0] vld, lst;
    exp = '{8'h01, 8'h02, 8'h03, 8'h04};
    dat = '{8'h01, 8'hEE, 8'h02, 8'hEE, 8'h03, 8'hEE, 8'h04};
    vld = 7'b1010101;
    lst = 7'b0100000;
    for (int c = 0; c < 7; c++) begin
      in_valid = vld[c]; in_data = dat[c]; in_last = lst[c]; step;
      if (c < 6) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL gap_early_valid[%0d]: got %b want 0", c, out_valid); end
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    n_cmp++; if (out_count !== 3'd4) begin n_err++; $display("FAIL gap_count: got %0d want 4", out_count); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out_data[i] !== exp[i]) begin n_err++; $display("FAIL gap_slot[%0d]: got %h want %h", i, out_data[i], exp[i]); end
    end
    out_ready = 1'b1; step; out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] exp [0:3];
    exp = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    in_valid = 1'b1; in_last = 1'b0;
    in_data = 8'h77; step;
    in_data = 8'h88; step;
    rst_n = 1'b0; in_data = 8'h99; step;
    rst_n = 1'b1; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_hs: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
    n_cmp++; if (out_count !== 3'd0) begin n_err++; $display("FAIL rmid_count: got %0d want 0", out_count); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out_data[i] !== 8'hFF) begin n_err++; $display("FAIL rmid_slot[%0d]: got %h want ff", i, out_data[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = exp[i]; in_last = (i == 3); step;
    end
    in_valid = 1'b0; in_last = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_count !== 3'd4) begin n_err++; $display("FAIL rmid_frame: got valid=%b count=%0d want 1/4", out_valid, out_count); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out_data[i] !== exp[i]) begin n_err++; $display("FAIL rmid_new_slot[%0d]: got %h want %h", i, out_data[i], exp[i]); end
    end
    out_ready = 1'b1; step; out_ready = 1'b0;
  endtask

  task automatic test_n1;
    int acc_cnt;
    logic acc;
    acc_cnt = 0;
    or1 = 1'b1; v1 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      d1 = 8'h10 + 8'(c); l1 = c[0];
      acc = r1;
      n_cmp++; if (acc !== (c % 2 == 0)) begin n_err++; $display("FAIL n1_ready[%0d]: got %b want %b", c, acc, c % 2 == 0); end
      step;
      if (acc === 1'b1) begin
        acc_cnt++;
        n_cmp++; if (ov1 !== 1'b1 || oc1 !== 1'b1 || od1[0] !== d1) begin n_err++; $display("FAIL n1_frame[%0d]: got valid=%b count=%0d data=%h want 1/1/%h", c, ov1, oc1, od1[0], d1); end
      end else begin
        n_cmp++; if (ov1 !== 1'b0 || od1[0] !== 8'hFF) begin n_err++; $display("FAIL n1_released[%0d]: got valid=%b data=%h want 0/ff", c, ov1, od1[0]); end
      end
    end
    v1 = 1'b0;
    n_cmp++; if (acc_cnt != 3) begin n_err++; $display("FAIL n1_rate: got %0d accepted want 3", acc_cnt); end
  endtask

  initial begin
    test_reset;
    test_full_frame;
    test_short_frame;
    test_backpressure;
    test_gapped;
    test_reset_mid_frame;
    test_n1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/and_gather.md
AND_GATHER -- requirements
Module: and_gather

Interface
REQ-001 Parameter N, default 2: number of word slots per frame; legal N >= 1.
REQ-002 Parameter WIDTH, default 1: bits per word; legal WIDTH >= 1.
REQ-003 Parameter CW, default $clog2(N+1): width of out_count; derived, not overridden.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1: reset, synchronous, active-low.
REQ-006 in_valid  input  1: upstream word present.
REQ-007 in_ready  output  1: block can accept a word this cycle.
REQ-008 in_data  input  WIDTH: upstream word.
REQ-009 in_last  input  1: qualified by in_valid; accepted word is the final word of a short frame.
REQ-010 out_valid  output  1: frame complete and held for the downstream AND-reduction tree.
REQ-011 out_ready  input  1: downstream accepts the frame.
REQ-012 out_data  output  unpacked array [0:N-1] of WIDTH: frame slots, index 0 = first accepted word.
REQ-013 out_count  output  CW: number of real (non-padded) words in the held frame, 1..N.

Function
REQ-014 Transfer in: a word is accepted on a cycle with in_valid && in_ready.
REQ-015 Transfer out: a frame is released on a cycle with out_valid && out_ready.
REQ-016 FSM has two states, FILL and FULL; reset state is FILL.
REQ-017 FILL: in_ready = 1, out_valid = 0.
REQ-018 FULL: in_ready = 0, out_valid = 1; in_valid is ignored.
REQ-019 Each accepted word is written to slot idx; idx is the write counter, range 0..N-1.
REQ-020 Frame completes when a word is accepted with idx == N-1 or with in_last = 1.
  - On completion: FILL -> FULL on the next edge.
  - out_count = idx+1.
  - idx returns to 0.
REQ-021 Otherwise an accepted word increments idx by 1; idx never wraps past N-1.
REQ-022 Unwritten slots of a short frame read all-ones (AND identity), so the downstream tree result is unaffected by padding.
REQ-023 On release, all slots are set to all-ones, out_count is set to 0 and the FSM goes FULL -> FILL on the next edge.
REQ-024 No bypass: a word offered on the release cycle is not accepted (in_ready = 0); at most one frame per N+1 cycles at full rate.
REQ-025 While FULL and out_ready = 0, out_data and out_count stay bit-stable every cycle.
REQ-026 out_valid, once asserted, stays 1 until release; it does not depend combinationally on out_ready.
REQ-027 in_ready depends only on state, never combinationally on in_valid or out_ready.
REQ-028 N == 1: every accepted word completes a frame with out_count = 1; in_last is don't-care.
REQ-029 in_last with idx == N-1 gives the same result as a full frame: out_count = N, no padding.

Reset
REQ-030 On a rising edge with rst_n = 0:
  - state = FILL, idx = 0.
  - All out_data slots = all-ones, out_count = 0.
  - out_valid = 0, in_ready = 1 from the following cycle.
REQ-031 Reset asserted mid-frame or while FULL discards the partial or held frame; no release occurs for it.
REQ-032 An input handshake on the reset cycle is ignored.

Verification (N=4, WIDTH=8)
REQ-033 Full frame: accept 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> next cycle out_valid = 1, out_data = {0x11, 0x22, 0x33, 0x44}, out_count = 4, in_ready = 0.
REQ-034 Short frame: accept 0xF0, then 0x0F with in_last = 1 -> out_data = {0xF0, 0x0F, 0xFF, 0xFF}, out_count = 2.
REQ-035 Backpressure:
  - Hold out_ready = 0 for 5 cycles after a frame completes -> out_data and out_count stable, in_ready = 0 throughout, in_valid ignored.
  - Raise out_ready -> release; next cycle in_ready = 1 and slots read all-ones.
REQ-036 Gapped input: in_valid toggled 1/0 over a frame -> only qualified words stored, in order, no slot skipped.
REQ-037 Reset mid-frame: accept 2 words, drive rst_n = 0 for one cycle -> out_valid = 0, out_count = 0, slots all-ones. A following 4-word frame occupies slots 0..3 with no stale data.
REQ-038 N=1 build: every accepted word -> out_valid next cycle, out_count = 1. Back-to-back offers with out_ready = 1 -> one word accepted every 2 cycles.
